// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - push-side bus of the buffered UART transmitter
interface uart_tx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  i_wr;
    logic [7:0]            i_data;
    logic                  o_full;
    logic                  o_empty;
    logic [DEPTH_LOG2:0]   o_count;
    logic                  o_overflow;

    modport master (
        output i_wr,
        output i_data,
        input  o_full,
        input  o_empty,
        input  o_count,
        input  o_overflow
    );

    modport slave (
        input  i_wr,
        input  i_data,
        output o_full,
        output o_empty,
        output o_count,
        output o_overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered UART transmitter, 8N1 or 8E1 when UART_TX_PARITY_EN is defined
module uart_tx_fifo #(
    parameter int                    DEPTH_LOG2      = 4,
    parameter int                    TIMER_BITS      = 32,
    parameter logic [TIMER_BITS-1:0] CLOCKS_PER_BAUD = TIMER_BITS'(868)
) (
    input  logic          clk,
    input  logic          i_reset_n,
    uart_tx_fifo_if.slave push,
    output logic          o_busy,
    output logic          o_txd
);

    localparam int                    DEPTH       = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [TIMER_BITS-1:0] BAUD_RELOAD = CLOCKS_PER_BAUD - TIMER_BITS'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        ,
        PARITY = 3'd4
`endif
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   count_next;
    logic                  full_r;
    logic                  empty_r;
    logic                  overflow_r;
    logic                  do_push;
    logic                  do_pop;
    logic [7:0]            head;

    // Serializer state
    state_t                state;
    state_t                state_next;
    logic [7:0]            shift;
    logic [7:0]            shift_next;
    logic [2:0]            bit_idx;
    logic [2:0]            bit_idx_next;
    logic [TIMER_BITS-1:0] timer;
    logic [TIMER_BITS-1:0] timer_next;
    logic                  baud_done;
    logic                  txd_r;
    logic                  txd_next;
`ifdef UART_TX_PARITY_EN
    logic                  parity_r;
    logic                  parity_next;
`endif

    // Acceptance uses the registered full flag, so a push racing a pop on a full FIFO is dropped
    assign do_push    = push.i_wr && !full_r;
    assign head       = mem[rd_ptr];
    assign count_next = count + {{DEPTH_LOG2{1'b0}}, do_push} - {{DEPTH_LOG2{1'b0}}, do_pop};
    assign baud_done  = (timer == '0);

    assign push.o_full     = full_r;
    assign push.o_empty    = empty_r;
    assign push.o_count    = count;
    assign push.o_overflow = overflow_r;
    assign o_busy          = (state != IDLE);
    assign o_txd           = txd_r;

    // FIFO data array; contents survive reset but become unreachable once the pointers clear
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push.i_data;
        end
    end

    // FIFO pointers, occupancy and registered status flags
    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            count   <= count_next;
            full_r  <= (count_next == FULL_COUNT);
            empty_r <= (count_next == '0);
            if (push.i_wr && full_r) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Serializer state register; the line is registered from the next-state decode
    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            state    <= IDLE;
            shift    <= '0;
            bit_idx  <= '0;
            timer    <= '0;
            txd_r    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_r <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            shift    <= shift_next;
            bit_idx  <= bit_idx_next;
            timer    <= timer_next;
            txd_r    <= txd_next;
`ifdef UART_TX_PARITY_EN
            parity_r <= parity_next;
`endif
        end
    end

    // Next-state decode: bit timing, shifting, and popping the next byte at frame boundaries
    always_comb begin
        state_next   = state;
        shift_next   = shift;
        bit_idx_next = bit_idx;
        timer_next   = baud_done ? timer : (timer - TIMER_BITS'(1));
        do_pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next  = parity_r;
`endif
        case (state)
            IDLE: begin
                if (!empty_r) begin
                    do_pop      = 1'b1;
                    shift_next  = head;
                    timer_next  = BAUD_RELOAD;
                    state_next  = START;
`ifdef UART_TX_PARITY_EN
                    parity_next = ^head;
`endif
                end
            end
            START: begin
                if (baud_done) begin
                    state_next   = DATA;
                    bit_idx_next = 3'd0;
                    timer_next   = BAUD_RELOAD;
                end
            end
            DATA: begin
                if (baud_done) begin
                    timer_next = BAUD_RELOAD;
                    shift_next = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_done) begin
                    state_next = STOP;
                    timer_next = BAUD_RELOAD;
                end
            end
`endif
            STOP: begin
                if (baud_done) begin
                    if (!empty_r) begin
                        // Chain straight into the next start bit with no idle gap
                        do_pop      = 1'b1;
                        shift_next  = head;
                        timer_next  = BAUD_RELOAD;
                        state_next  = START;
`ifdef UART_TX_PARITY_EN
                        parity_next = ^head;
`endif
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Line level implied by the state being entered
    always_comb begin
        txd_next = 1'b1;
        case (state_next)
            IDLE:    txd_next = 1'b1;
            START:   txd_next = 1'b0;
            DATA:    txd_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd_next = parity_next;
`endif
            STOP:    txd_next = 1'b1;
            default: txd_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

    localparam int DL2 = 2;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FL = CPB * FB;

    typedef struct {
        int   off;
        logic txd;
        logic busy;
        logic empty;
        int   count;
    } vec_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy;
    logic       txd;
    int         cyc       = 0;
    int         checks    = 0;
    int         errors    = 0;
    int         frames_rx = 0;
    logic [7:0] sb[$];
    int         starts[$];

    int         mon_pos  = -1;
    logic [7:0] mon_exp  = 8'h00;
    bit         mon_have = 1'b0;

    uart_tx_fifo_if #(.DEPTH_LOG2(DL2)) bus();

    uart_tx_fifo #(
        .DEPTH_LOG2     (DL2),
        .TIMER_BITS     (32),
        .CLOCKS_PER_BAUD(32'(CPB))
    ) dut (
        .clk      (clk),
        .i_reset_n(rst_n),
        .push     (bus.slave),
        .o_busy   (busy),
        .o_txd    (txd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Line decoder: pops the scoreboard at each start bit, checks every bit mid-period
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            mon_pos = -1;
        end else if (mon_pos < 0) begin
            if (txd === 1'b0) begin
                mon_pos = 0;
                starts.push_back(cyc);
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    mon_have = 1'b0;
                    $display("FAIL unexpected_frame: got frame at cycle %0d expected none", cyc);
                end else begin
                    mon_exp  = sb.pop_front();
                    mon_have = 1'b1;
                end
            end
        end else begin
            mon_pos++;
        end
        if (mon_pos >= 0) begin
            if (mon_pos == CPB / 2) chk("start_bit", txd, 1'b0);
            for (int i = 0; i < 8; i++) begin
                if (mon_have && mon_pos == CPB * (1 + i) + CPB / 2)
                    chk($sformatf("data_bit%0d_of_%02h", i, mon_exp), txd, mon_exp[i]);
            end
`ifdef UART_TX_PARITY_EN
            if (mon_have && mon_pos == CPB * 9 + CPB / 2)
                chk($sformatf("parity_of_%02h", mon_exp), txd, ^mon_exp);
`endif
            if (mon_pos == CPB * (FB - 1) + CPB / 2) chk("stop_bit", txd, 1'b1);
            if (mon_pos == FL - 1) begin
                mon_pos = -1;
                frames_rx++;
            end
        end
    end

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((busy !== 1'b0 || bus.o_empty !== 1'b1) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_idle_timeout"}, n < 5000, 1);
        repeat (3) @(negedge clk);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic parity_frame(input logic [7:0] d, input logic exp_par);
        int   bc;
        logic pbit;
        bc   = 0;
        pbit = 1'bx;
        @(negedge clk);
        bus.i_wr   = 1'b1;
        bus.i_data = d;
        sb.push_back(d);
        for (int off = 1; off <= FL + 4; off++) begin
            @(negedge clk);
            bus.i_wr = 1'b0;
            if (busy === 1'b1) bc++;
            if (off == 2 + CPB * 9 + CPB / 2) pbit = txd;
        end
        chk($sformatf("par_bit_%02h", d), pbit, exp_par);
        chk($sformatf("par_busy_cycles_%02h", d), bc, FL);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[11];
        int   busy_cnt;
        int   f0;
        int   pushed;
        int   n;

        vecs[0]  = '{1,      1'b1, 1'b0, 1'b0, 1};
        vecs[1]  = '{2,      1'b0, 1'b1, 1'b1, 0};
        vecs[2]  = '{5,      1'b0, 1'b1, 1'b1, 0};
        vecs[3]  = '{6,      1'b1, 1'b1, 1'b1, 0};
        vecs[4]  = '{9,      1'b1, 1'b1, 1'b1, 0};
        vecs[5]  = '{10,     1'b0, 1'b1, 1'b1, 0};
        vecs[6]  = '{13,     1'b0, 1'b1, 1'b1, 0};
        vecs[7]  = '{30,     1'b1, 1'b1, 1'b1, 0};
        vecs[8]  = '{37,     1'b0, 1'b1, 1'b1, 0};
        vecs[9]  = '{FL + 1, 1'b1, 1'b1, 1'b1, 0};
        vecs[10] = '{FL + 2, 1'b1, 1'b0, 1'b1, 0};

        bus.i_wr   = 1'b0;
        bus.i_data = 8'h00;
        rst_n      = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_txd", txd, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_empty", bus.o_empty, 1'b1);
        chk("rst_full", bus.o_full, 1'b0);
        chk("rst_count", bus.o_count, 0);
        chk("rst_overflow", bus.o_overflow, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte 0x55 from idle, table-driven per-offset checks
        @(negedge clk);
        bus.i_wr   = 1'b1;
        bus.i_data = 8'h55;
        sb.push_back(8'h55);
        busy_cnt = 0;
        for (int off = 1; off <= FL + 4; off++) begin
            @(negedge clk);
            bus.i_wr = 1'b0;
            if (busy === 1'b1) busy_cnt++;
            for (int v = 0; v < 11; v++) begin
                if (vecs[v].off == off) begin
                    chk($sformatf("t1_txd_off%0d", off), txd, vecs[v].txd);
                    chk($sformatf("t1_busy_off%0d", off), busy, vecs[v].busy);
                    chk($sformatf("t1_empty_off%0d", off), bus.o_empty, vecs[v].empty);
                    chk($sformatf("t1_count_off%0d", off), bus.o_count, vecs[v].count);
                end
            end
        end
        chk("t1_busy_cycles", busy_cnt, FL);
        wait_idle("t1");

        // Three back-to-back bytes
        starts.delete();
        f0 = frames_rx;
        @(negedge clk);
        bus.i_wr = 1'b1; bus.i_data = 8'hA1; sb.push_back(8'hA1);
        @(negedge clk);
        bus.i_data = 8'h00; sb.push_back(8'h00);
        @(negedge clk);
        bus.i_data = 8'hFF; sb.push_back(8'hFF);
        for (int off = 3; off <= 2 * FL + 4; off++) begin
            @(negedge clk);
            bus.i_wr = 1'b0;
            if (off == 3)          chk("t2_count_settled", bus.o_count, 2);
            if (off == FL + 1)     chk("t2_count_before_pop2", bus.o_count, 2);
            if (off == FL + 2)     chk("t2_count_after_pop2", bus.o_count, 1);
            if (off == 2 * FL + 1) chk("t2_count_before_pop3", bus.o_count, 1);
            if (off == 2 * FL + 2) chk("t2_count_after_pop3", bus.o_count, 0);
        end
        wait_idle("t2");
        chk("t2_frames", frames_rx - f0, 3);
        chk("t2_starts", starts.size(), 3);
        if (starts.size() == 3) begin
            chk("t2_gap1", starts[1] - starts[0], FL);
            chk("t2_gap2", starts[2] - starts[1], FL);
        end

        // Overflow: six pushes into a depth-4 FIFO, the sixth is dropped
        f0 = frames_rx;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 5) begin
                chk("t3_full_at4", bus.o_full, 1'b1);
                chk("t3_count_at4", bus.o_count, 4);
                chk("t3_no_overflow_yet", bus.o_overflow, 1'b0);
            end
            bus.i_wr   = 1'b1;
            bus.i_data = 8'(16 + k * 17);
            if (k < 5) sb.push_back(8'(16 + k * 17));
        end
        @(negedge clk);
        bus.i_wr = 1'b0;
        chk("t3_overflow_set", bus.o_overflow, 1'b1);
        chk("t3_count_held", bus.o_count, 4);
        @(negedge clk);
        wait_idle("t3");
        chk("t3_frames", frames_rx - f0, 5);
        chk("t3_overflow_sticky", bus.o_overflow, 1'b1);

        // Reset clears the sticky flag
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("t4_rst_overflow", bus.o_overflow, 1'b0);
        chk("t4_rst_count", bus.o_count, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Stream 20 bytes with full-based flow control
        f0     = frames_rx;
        pushed = 0;
        n      = 0;
        while (pushed < 20 && n < 20000) begin
            @(negedge clk);
            n++;
            if (bus.o_full === 1'b0) begin
                bus.i_wr   = 1'b1;
                bus.i_data = 8'($urandom);
                sb.push_back(bus.i_data);
                pushed++;
            end else begin
                bus.i_wr = 1'b0;
            end
        end
        @(negedge clk);
        bus.i_wr = 1'b0;
        chk("t4_pushed", pushed, 20);
        @(negedge clk);
        wait_idle("t4");
        chk("t4_frames", frames_rx - f0, 20);
        chk("t4_overflow", bus.o_overflow, 1'b0);
        chk("t4_sb_drained", sb.size(), 0);

        // Reset in the middle of data bit 3, then a clean frame
        f0 = frames_rx;
        @(negedge clk);
        bus.i_wr   = 1'b1;
        bus.i_data = 8'h3C;
        sb.push_back(8'h3C);
        for (int off = 1; off <= 2 + CPB * 4 + CPB / 2; off++) begin
            @(negedge clk);
            bus.i_wr = 1'b0;
        end
        chk("t5_pre_bit3", txd, 1'b1);
        chk("t5_pre_busy", busy, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_txd", txd, 1'b1);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_count", bus.o_count, 0);
        chk("t5_rst_empty", bus.o_empty, 1'b1);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("t5_aborted_not_counted", frames_rx - f0, 0);
        chk("t5_sb_after_abort", sb.size(), 0);
        bus.i_wr   = 1'b1;
        bus.i_data = 8'h3C;
        sb.push_back(8'h3C);
        @(negedge clk);
        bus.i_wr = 1'b0;
        @(negedge clk);
        wait_idle("t5");
        chk("t5_clean_frame", frames_rx - f0, 1);

`ifdef UART_TX_PARITY_EN
        // Even parity bit and 11-bit frame length
        parity_frame(8'h07, 1'b1);
        wait_idle("t6a");
        parity_frame(8'h03, 1'b0);
        wait_idle("t6b");
`endif

        chk("final_sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
